// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Passive monitor for the 4-bit HD44780-style character-LCD bus.
//   It reassembles strobed nibbles into bytes, decodes the cursor and clear
//   commands, and keeps a 2x16 shadow copy of display RAM that can be read
//   back through a registered read port.
//
// Ports
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   LCD_D[4:0] bit 4 = RS, bits 3:0 = nibble (asynchronous to CLK)
//   LCD_E      enable strobe (asynchronous to CLK)
//   rd_addr    shadow read index, 0-15 line 0, 16-31 line 1
//   rd_char    registered character at rd_addr (0x20 for never-written cells)
//   byte_valid one-cycle pulse per assembled byte
//   byte_data  last assembled byte
//   byte_rs    RS of the last assembled byte
//   cursor     current shadow write index
//   mode4      receiver has seen the 4-bit function-set nibble
//   err        one-cycle pulse on RS mismatch or nibble timeout
module lcd_bus_receiver #(
  parameter int E_MIN_HIGH     = 12,
  parameter int NIBBLE_TIMEOUT = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] LCD_D,
  input  logic       LCD_E,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic [4:0] cursor,
  output logic       mode4,
  output logic       err
);

  localparam int HW = $clog2(E_MIN_HIGH + 1);
  localparam int TW = $clog2(NIBBLE_TIMEOUT + 1);
  localparam logic [HW-1:0] E_MAX   = HW'(E_MIN_HIGH);
  localparam logic [TW-1:0] TO_LAST = TW'(NIBBLE_TIMEOUT - 1);

  localparam logic [1:0] ST_MODE8 = 2'd0;
  localparam logic [1:0] ST_HI    = 2'd1;
  localparam logic [1:0] ST_LO    = 2'd2;

  logic          e_s1_q, e_s1_d, e_s2_q, e_s2_d, e_prev_q, e_prev_d;
  logic [4:0]    d_s1_q, d_s1_d, d_s2_q, d_s2_d, d_hold_q, d_hold_d;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic          hi_rs_q, hi_rs_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_rs_q, byte_rs_d;
  logic          mode4_q, mode4_d;
  logic          err_q, err_d;
  logic [4:0]    cursor_q, cursor_d;
  logic [31:0]   valid_q, valid_d;
  logic [7:0]    rd_char_q, rd_char_d;
  logic [7:0]    shadow_q [32];

  logic          nib_accept;
  logic          nib_rs;
  logic [3:0]    nib_val;
  logic [7:0]    asm_byte;
  logic          byte_done;
  logic          wr_en;

  // Synchronizers plus the E-high width counter. The data nibble is captured
  // on every synchronized-high cycle so the value in d_hold_q on the fall
  // cycle is the one seen during the last high cycle. The counter returns to
  // zero whenever E is low, so each pulse is measured from scratch.
  always_comb begin
    e_s1_d   = LCD_E;
    e_s2_d   = e_s1_q;
    e_prev_d = e_s2_q;
    d_s1_d   = LCD_D;
    d_s2_d   = d_s1_q;
    d_hold_d = d_hold_q;
    hi_cnt_d = '0;
    if (e_s2_q) begin
      d_hold_d = d_s2_q;
      hi_cnt_d = (hi_cnt_q == E_MAX) ? hi_cnt_q : hi_cnt_q + 1'b1;
    end
  end

  assign nib_accept = e_prev_q & ~e_s2_q & (hi_cnt_q == E_MAX);
  assign nib_rs     = d_hold_q[4];
  assign nib_val    = d_hold_q[3:0];
  assign asm_byte   = {hi_nib_q, nib_val};

  // Nibble FSM: MODE8 waits for the 4-bit function-set nibble, then HI/LO
  // alternate. An RS mismatch in LO restarts the byte with the new nibble as
  // its high half; the timeout only runs while a high nibble is pending.
  always_comb begin
    state_d      = state_q;
    hi_nib_d     = hi_nib_q;
    hi_rs_d      = hi_rs_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_rs_d    = byte_rs_q;
    mode4_d      = mode4_q;
    err_d        = 1'b0;
    byte_done    = 1'b0;
    case (state_q)
      ST_MODE8: begin
        if (nib_accept && !nib_rs && nib_val == 4'h2) begin
          state_d = ST_HI;
          mode4_d = 1'b1;
        end
      end
      ST_HI: begin
        if (nib_accept) begin
          hi_nib_d = nib_val;
          hi_rs_d  = nib_rs;
          to_cnt_d = '0;
          state_d  = ST_LO;
        end
      end
      ST_LO: begin
        if (nib_accept) begin
          if (nib_rs == hi_rs_q) begin
            byte_done    = 1'b1;
            byte_valid_d = 1'b1;
            byte_data_d  = asm_byte;
            byte_rs_d    = nib_rs;
            state_d      = ST_HI;
          end else begin
            err_d    = 1'b1;
            hi_nib_d = nib_val;
            hi_rs_d  = nib_rs;
            to_cnt_d = '0;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_HI;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_MODE8;
    endcase
  end

  // Byte decode: data bytes land at the cursor and advance it (wrapping at
  // 32 via natural 5-bit overflow); only clear, home and the two in-range
  // DDRAM address windows touch the cursor or valid bits.
  always_comb begin
    cursor_d = cursor_q;
    valid_d  = valid_q;
    wr_en    = 1'b0;
    if (byte_done) begin
      if (nib_rs) begin
        wr_en             = 1'b1;
        valid_d[cursor_q] = 1'b1;
        cursor_d          = cursor_q + 5'd1;
      end else begin
        case (asm_byte)
          8'h01: begin
            valid_d  = '0;
            cursor_d = '0;
          end
          8'h02, 8'h03: cursor_d = '0;
          default: begin
            if (asm_byte[7:4] == 4'h8) begin
              cursor_d = {1'b0, asm_byte[3:0]};
            end else if (asm_byte[7:4] == 4'hC) begin
              cursor_d = {1'b1, asm_byte[3:0]};
            end
          end
        endcase
      end
    end
  end

  // Read port uses the current (pre-update) arrays, giving read-before-write.
  always_comb begin
    rd_char_d = valid_q[rd_addr] ? shadow_q[rd_addr] : 8'h20;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      e_s1_q       <= 1'b0;
      e_s2_q       <= 1'b0;
      e_prev_q     <= 1'b0;
      d_s1_q       <= '0;
      d_s2_q       <= '0;
      d_hold_q     <= '0;
      hi_cnt_q     <= '0;
      to_cnt_q     <= '0;
      state_q      <= ST_MODE8;
      hi_nib_q     <= '0;
      hi_rs_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_rs_q    <= 1'b0;
      mode4_q      <= 1'b0;
      err_q        <= 1'b0;
      cursor_q     <= '0;
      valid_q      <= '0;
      rd_char_q    <= 8'h20;
    end else begin
      e_s1_q       <= e_s1_d;
      e_s2_q       <= e_s2_d;
      e_prev_q     <= e_prev_d;
      d_s1_q       <= d_s1_d;
      d_s2_q       <= d_s2_d;
      d_hold_q     <= d_hold_d;
      hi_cnt_q     <= hi_cnt_d;
      to_cnt_q     <= to_cnt_d;
      state_q      <= state_d;
      hi_nib_q     <= hi_nib_d;
      hi_rs_q      <= hi_rs_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_rs_q    <= byte_rs_d;
      mode4_q      <= mode4_d;
      err_q        <= err_d;
      cursor_q     <= cursor_d;
      valid_q      <= valid_d;
      rd_char_q    <= rd_char_d;
    end
  end

  // Shadow data needs no reset; the valid bits decide what is visible.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      shadow_q[cursor_q] <= asm_byte;
    end
  end

  assign rd_char    = rd_char_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_rs    = byte_rs_q;
  assign cursor     = cursor_q;
  assign mode4      = mode4_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver
//   Self-checking bench for lcd_bus_receiver. Bytes expected on byte_valid
//   are pushed to a queue as they are sent and popped by a monitor when the
//   receiver reports them; each scenario task also checks cursor, mode4,
//   err pulses and shadow contents directly.
module tb_lcd_bus_receiver;

  localparam int EMH = 12;
  localparam int NTO = 300;

  logic       CLK;
  logic       RST_N;
  logic [4:0] LCD_D;
  logic       LCD_E;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_rs;
  logic [4:0] cursor;
  logic       mode4;
  logic       err;

  int passed = 0;
  int total  = 0;
  int bv_count  = 0;
  int err_count = 0;
  logic [8:0] exp_q [$];

  lcd_bus_receiver #(.E_MIN_HIGH(EMH), .NIBBLE_TIMEOUT(NTO)) dut (
    .CLK(CLK), .RST_N(RST_N), .LCD_D(LCD_D), .LCD_E(LCD_E),
    .rd_addr(rd_addr), .rd_char(rd_char), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_rs(byte_rs), .cursor(cursor),
    .mode4(mode4), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard monitor: every byte_valid cycle must match the oldest
  // expected {rs, byte}; err pulses are tallied for the scenario tasks.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (byte_valid) begin
        logic [8:0] e;
        bv_count++;
        total++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_byte: got rs=%0d data=%h, none expected", byte_rs, byte_data);
        end else begin
          e = exp_q.pop_front();
          if ({byte_rs, byte_data} !== e)
            $display("[TB] FAIL byte: got rs=%0d data=%h want rs=%0d data=%h", byte_rs, byte_data, e[8], e[7:0]);
          else
            passed++;
        end
      end
      if (err) err_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_nibble(input logic rs, input logic [3:0] nib, input int high);
    LCD_D = {rs, nib};
    tick(4);
    LCD_E = 1'b1;
    tick(high);
    LCD_E = 1'b0;
    tick(7);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b});
    send_nibble(rs, b[7:4], EMH + 2);
    send_nibble(rs, b[3:0], EMH + 2);
  endtask

  task automatic send_text(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i]);
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    tick(2);
    d = rd_char;
  endtask

  task automatic check_cell(input string name, input logic [4:0] a, input logic [7:0] want);
    logic [7:0] d;
    read_cell(a, d);
    total++;
    if (d !== want) $display("[TB] FAIL %s: rd_char[%0d] got %h want %h", name, a, d, want);
    else passed++;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got !== want) $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    else passed++;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; LCD_E = 1'b0; LCD_D = '0; rd_addr = '0;
    tick(3);
    RST_N = 1'b1;
    tick(2);
    check_val("reset_mode4", mode4, 0);
    check_val("reset_cursor", cursor, 0);
    check_val("reset_byte_valid", byte_valid, 0);
    check_val("reset_err", err, 0);
    check_val("reset_byte_data", byte_data, 0);
    check_val("reset_byte_rs", byte_rs, 0);
    check_val("reset_rd_char", rd_char, 8'h20);
  endtask

  task automatic test_init;
    send_nibble(1'b0, 4'h3, EMH + 2);
    send_nibble(1'b0, 4'h3, EMH + 2);
    send_nibble(1'b0, 4'h3, EMH + 2);
    check_val("init_mode4_before", mode4, 0);
    send_nibble(1'b0, 4'h2, EMH + 2);
    check_val("init_mode4", mode4, 1);
    check_val("init_no_bytes", bv_count, 0);
  endtask

  task automatic test_text_write;
    int bv0;
    bv0 = bv_count;
    send_byte(1'b0, 8'h28);
    send_byte(1'b0, 8'h0C);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h80);
    send_text("abcdefghijklmnop");
    check_val("text_cursor_line0_end", cursor, 16);
    send_byte(1'b0, 8'hC0);
    send_text("qrstuvwxyz123456");
    check_val("text_byte_count", bv_count - bv0, 37);
    check_val("text_cursor_wrap", cursor, 0);
    check_cell("text_cell0", 5'd0, 8'h61);
    check_cell("text_cell5", 5'd5, 8'h66);
    check_cell("text_cell15", 5'd15, 8'h70);
    check_cell("text_cell16", 5'd16, 8'h71);
    check_cell("text_cell31", 5'd31, 8'h36);
  endtask

  task automatic test_clear;
    send_byte(1'b0, 8'h01);
    check_val("clear_cursor", cursor, 0);
    for (int i = 0; i < 32; i++) check_cell("clear_cell", 5'(i), 8'h20);
    send_byte(1'b1, 8'h5A);
    check_cell("clear_then_Z", 5'd0, 8'h5A);
    check_cell("clear_then_Z_next", 5'd1, 8'h20);
    check_val("clear_then_Z_cursor", cursor, 1);
  endtask

  task automatic test_cursor_cmds;
    send_byte(1'b0, 8'hCF);
    check_val("cmd_c_f", cursor, 31);
    send_byte(1'b0, 8'h90);
    check_val("cmd_out_of_range", cursor, 31);
    send_byte(1'b1, 8'h57);
    check_val("cmd_wrap31", cursor, 0);
    check_cell("cmd_cell31", 5'd31, 8'h57);
    send_byte(1'b0, 8'h8A);
    check_val("cmd_8a", cursor, 10);
    send_byte(1'b0, 8'h03);
    check_val("cmd_home", cursor, 0);
    check_cell("cmd_home_kept", 5'd31, 8'h57);
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_count;
    send_nibble(1'b1, 4'h7, EMH - 1);
    send_byte(1'b1, 8'h41);
    check_val("glitch_no_err", err_count - e0, 0);
    check_cell("glitch_cell0", 5'd0, 8'h41);
    check_val("glitch_cursor", cursor, 1);
  endtask

  task automatic test_timeout;
    int e0, b0;
    e0 = err_count;
    b0 = bv_count;
    send_nibble(1'b1, 4'h4, EMH + 2);
    tick(NTO + 20);
    check_val("timeout_err", err_count - e0, 1);
    check_val("timeout_no_byte", bv_count - b0, 0);
    send_byte(1'b1, 8'h42);
    check_cell("timeout_next_byte", 5'd1, 8'h42);
    check_val("timeout_cursor", cursor, 2);
  endtask

  task automatic test_rs_mismatch;
    int e0, b0;
    send_byte(1'b0, 8'h85);
    check_val("mismatch_setup_cursor", cursor, 5);
    e0 = err_count;
    b0 = bv_count;
    send_nibble(1'b1, 4'h4, EMH + 2);
    send_nibble(1'b0, 4'h8, EMH + 2);
    check_val("mismatch_err", err_count - e0, 1);
    check_val("mismatch_no_byte", bv_count - b0, 0);
    check_val("mismatch_cursor_kept", cursor, 5);
    check_cell("mismatch_no_write", 5'd5, 8'h20);
    exp_q.push_back({1'b0, 8'h81});
    send_nibble(1'b0, 4'h1, EMH + 2);
    check_val("mismatch_resync_cursor", cursor, 1);
    check_val("mismatch_resync_byte", bv_count - b0, 1);
  endtask

  task automatic test_reset_mid_byte;
    int b0;
    send_nibble(1'b1, 4'h4, EMH + 2);
    RST_N = 1'b0;
    tick(1);
    RST_N = 1'b1;
    tick(2);
    check_val("midrst_mode4", mode4, 0);
    check_val("midrst_cursor", cursor, 0);
    check_cell("midrst_cell0", 5'd0, 8'h20);
    check_cell("midrst_cell1", 5'd1, 8'h20);
    b0 = bv_count;
    send_nibble(1'b1, 4'h4, EMH + 2);
    send_nibble(1'b1, 4'h1, EMH + 2);
    check_val("midrst_ignored", bv_count - b0, 0);
    check_val("midrst_cursor_after", cursor, 0);
    check_val("midrst_mode4_after", mode4, 0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_text_write();
    test_clear();
    test_cursor_cmds();
    test_glitch();
    test_timeout();
    test_rs_mismatch();
    test_reset_mid_byte();
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
